// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, break handling and output FIFO.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 31250,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          ferr_o,
  output logic                          perr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  input  logic                          clr_i,
  output logic                          busy_o
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
`ifdef UART_RX_PARITY_EN
  localparam int EW   = DATA_BITS + 2;
`else
  localparam int EW   = DATA_BITS + 1;
`endif

  if (CPB < 8) begin : g_bad_cpb
    $error("uart_rx_fifo: CLK_HZ/BAUD must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_odd
    $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rxs_q;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  vote, at_s0, at_s1, at_mid, at_end;
  logic                  push, push_ferr;
  logic [EW-1:0]         din;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [EW-1:0]         head_q, head_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [LW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  do_push, do_pop, full;

`ifdef UART_RX_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  assign at_s0  = (cyc_q == CW'(HALF - 1));
  assign at_s1  = (cyc_q == CW'(HALF));
  assign at_mid = (cyc_q == CW'(HALF + 1));
  assign at_end = (cyc_q == CW'(CPB - 1));
  assign vote   = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    push      = 1'b0;
    push_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
`endif
    if (state_q != S_IDLE && state_q != S_BREAK) begin
      cyc_d = at_end ? '0 : cyc_q + 1'b1;
      if (at_s0) s0_d = rxs_q;
      if (at_s1) s1_d = rxs_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cyc_d   = '0;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (at_mid && vote) state_d = S_IDLE;
        else if (at_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (at_mid) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_mid) perr_d = vote ^ (^shift_q) ^ PARITY_ODD[0];
        if (at_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Push at mid-stop so the next start edge has half a bit of slack.
        if (at_mid) begin
          push      = 1'b1;
          push_ferr = ~vote;
          state_d   = vote ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign din = {perr_q, push_ferr, shift_q};
`else
  assign din = {push_ferr, shift_q};
`endif

  assign full    = (count_q == LW'(FIFO_DEPTH));
  assign do_pop  = valid_o & ready_i;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr_q + 1'b1;

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_nxt;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head register mirrors mem[rd_ptr] so outputs stay flop-driven.
    if (do_pop) begin
      if (count_q > LW'(1)) head_d = mem_q[rd_nxt];
      else if (do_push)     head_d = din;
    end else if (do_push && count_q == '0) begin
      head_d = din;
    end
    if (clr_i)                     overrun_d = 1'b0;
    else if (push && full && !do_pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      head_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      head_q    <= head_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      mem_q     <= mem_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o    = head_q[DATA_BITS-1:0];
  assign ferr_o    = head_q[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign perr_o    = head_q[DATA_BITS+1];
`else
  assign perr_o    = 1'b0;
`endif
  assign valid_o   = (count_q != '0);
  assign level_o   = count_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo at CPB=32, 8 data bits.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 32;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PUSH_LAT = 3 + CPB * (NB - 1) + CPB / 2 + 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic       clr_i = 1'b0;
  logic [7:0] data_o;
  logic       ferr_o, perr_o, valid_o, overrun_o, busy_o;
  logic [2:0] level_o;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int t_start = 0;
  int t_rise = -1;
  logic valid_prev = 1'b0;
  logic [9:0] exp_q[$];

  uart_rx_fifo #(
    .CLK_HZ(1_000_000), .BAUD(31250), .DATA_BITS(8),
    .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .data_o(data_o), .ferr_o(ferr_o), .perr_o(perr_o),
    .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
    .overrun_o(overrun_o), .clr_i(clr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    #1;
    if (valid_o && !valid_prev) t_rise = cyc_cnt;
    valid_prev = valid_o;
    if (!rst_i && valid_o && ready_i) begin
      check("pop_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_data", data_o, e[7:0]);
        check("pop_ferr", ferr_o, e[8]);
        check("pop_perr", perr_o, e[9]);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic bad_par, input logic glitch);
    logic [NB-1:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, (^d) ^ bad_par, d, 1'b0};
`else
    bits = {stop, d, 1'b0};
`endif
    t_start = cyc_cnt;
    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < CPB; j++) begin
        rx_i = (glitch && j == 17) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
    rx_i = stop;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_i = 1'b1;
    while (valid_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", valid_o, 0);
    ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] ob [5];
    ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33;
    ob[3] = 8'h44; ob[4] = 8'h55;

    repeat (4) @(negedge clk);
    check("rst_data", data_o, 0);
    check("rst_ferr", ferr_o, 0);
    check("rst_perr", perr_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    ready_i = 1'b1;
    exp_q.push_back({2'b00, 8'h90});
    send_frame(8'h90, 1'b1, 1'b0, 1'b0);
    check("push_latency", t_rise - t_start, PUSH_LAT);
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({2'b00, 8'h7F});
    send_frame(8'h7F, 1'b1, 1'b0, 1'b0);
    repeat (CPB) @(negedge clk);
    check("clean_level", level_o, 0);

    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    check("fstart_busy", busy_o, 1);
    repeat (17) @(negedge clk);
    check("fstart_idle", busy_o, 0);
    check("fstart_level", level_o, 0);

    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("noise_level", level_o, 0);

    exp_q.push_back({2'b01, 8'h55});
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    check("break_busy", busy_o, 1);
    rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("break_level", level_o, 0);
    check("break_pending", exp_q.size(), 0);
    exp_q.push_back({2'b00, 8'h12});
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({2'b00, ob[i]});
      send_frame(ob[i], 1'b1, 1'b0, 1'b0);
    end
    check("ovr_level", level_o, 4);
    check("ovr_flag", overrun_o, 1);
    check("ovr_head", data_o, 8'h11);
    drain();
    check("ovr_sticky", overrun_o, 1);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check("ovr_clr", overrun_o, 0);

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'b00, 8'hA1 + 8'(i)});
      send_frame(8'hA1 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    check("full_level", level_o, 4);
    exp_q.push_back({2'b00, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      begin
        repeat (PUSH_LAT - 1) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
      end
    join
    check("pp_overrun", overrun_o, 0);
    check("pp_level", level_o, 4);
    check("pp_head", data_o, 8'hA2);
    drain();
    check("pp_overrun_end", overrun_o, 0);

`ifdef UART_RX_PARITY_EN
    ready_i = 1'b1;
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({2'b10, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    ready_i = 1'b0;
`endif

    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (NB * CPB) @(negedge clk);
    check("mid_level", level_o, 0);
    check("mid_valid", valid_o, 0);
    check("mid_busy_end", busy_o, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
